// File: rtl/vga_mat_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the matrix BCD formatter.
package vga_mat_pkg;

  localparam int N_ELEM = 9;
  localparam int BCD_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    WAIT_VB = 2'd3
  } state_t;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 on the next shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] nib);
    logic [BCD_W-1:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  function automatic int digit_lsb(input int k, input int d, input int digits);
    return (k * digits + d) * BCD_W;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 binary to BCD core; bcd presents the digits after the current step.
module bin2bcd_serial
  import vga_mat_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [DATA_W-1:0]         din,
  input  logic                      shift,
  output logic [DIGITS*BCD_W-1:0]   bcd
);

  logic [DATA_W-1:0]       bin_sr;
  logic [DIGITS*BCD_W-1:0] bcd_sr;
  logic [DIGITS*BCD_W-1:0] bcd_adj_s;

  // Correct every nibble before the shift.
  always_comb begin
    bcd_adj_s = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bcd_adj_s[d*BCD_W +: BCD_W] = add3(bcd_sr[d*BCD_W +: BCD_W]);
    end
  end

  assign bcd = {bcd_adj_s[DIGITS*BCD_W-2:0], bin_sr[DATA_W-1]};

  // Shift register pair, loaded once per element and shifted DATA_W times.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_sr <= '0;
      bcd_sr <= '0;
    end else if (load) begin
      bin_sr <= din;
      bcd_sr <= '0;
    end else if (shift) begin
      bin_sr <= bin_sr << 1;
      bcd_sr <= bcd;
    end
  end

endmodule

// File: rtl/matrix_bcd_formatter.sv
// Converts a 3x3 matrix of unsigned values to BCD digits and leading-zero masks,
// committing the whole frame atomically during vertical blank.
module matrix_bcd_formatter
  import vga_mat_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_ELEM*DATA_W-1:0]         in_data,
  input  logic                             vblank,
  output logic [N_ELEM*DIGITS*BCD_W-1:0]   bcd_out,
  output logic [N_ELEM*DIGITS-1:0]         blank_out,
  output logic                             busy,
  output logic                             frame_updated
);

  localparam int DW    = DIGITS * BCD_W;
  localparam int K_W   = $clog2(N_ELEM);
  localparam int CNT_W = $clog2(DATA_W + 1);

  generate
    if ((10 ** DIGITS) <= ((2 ** DATA_W) - 1)) begin : g_bad_cfg
      $error("matrix_bcd_formatter: DIGITS too small for DATA_W");
    end
  endgenerate

  function automatic logic [N_ELEM*DIGITS-1:0] blank_reset();
    logic [N_ELEM*DIGITS-1:0] m;
    m = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      for (int d = 1; d < DIGITS; d++) begin
        m[k*DIGITS+d] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [N_ELEM*DIGITS-1:0] BLANK_RST = blank_reset();

  // A digit is blanked when it and every more significant digit are zero; the LSD always shows.
  function automatic logic [DIGITS-1:0] blank_of(input logic [DW-1:0] b);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zero_above = zero_above & (b[d*BCD_W +: BCD_W] == 4'd0);
      m[d]       = (d > 0) ? zero_above : 1'b0;
    end
    return m;
  endfunction

  state_t                     state_r;
  state_t                     state_next_s;
  logic [K_W-1:0]             k_r;
  logic [CNT_W-1:0]           cnt_r;
  logic [N_ELEM*DATA_W-1:0]   data_r;
  logic [N_ELEM*DW-1:0]       shadow_bcd_r;
  logic [N_ELEM*DIGITS-1:0]   shadow_blank_r;
  logic [DW-1:0]              core_bcd_s;
  logic [DATA_W-1:0]          elem_s;
  logic                       accept_s;
  logic                       last_shift_s;
  logic                       commit_s;

  assign accept_s     = (state_r == IDLE) && in_valid;
  assign last_shift_s = (state_r == SHIFT) && (cnt_r == CNT_W'(DATA_W - 1));
  assign commit_s     = (state_r == WAIT_VB) && vblank;
  assign elem_s       = data_r[int'(k_r)*DATA_W +: DATA_W];

  bin2bcd_serial #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state_r == LOAD),
    .din     (elem_s),
    .shift   (state_r == SHIFT),
    .bcd     (core_bcd_s)
  );

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = LOAD;
        else          state_next_s = IDLE;
      end
      LOAD:  state_next_s = SHIFT;
      SHIFT: begin
        if (!last_shift_s)                     state_next_s = SHIFT;
        else if (k_r == K_W'(N_ELEM - 1))      state_next_s = WAIT_VB;
        else                                   state_next_s = LOAD;
      end
      WAIT_VB: begin
        if (vblank) state_next_s = IDLE;
        else        state_next_s = WAIT_VB;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state, element index, shift counter, input capture and handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      k_r      <= '0;
      cnt_r    <= '0;
      data_r   <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      in_ready <= (state_next_s == IDLE);
      busy     <= (state_next_s != IDLE);
      if (accept_s) begin
        data_r <= in_data;
        k_r    <= '0;
      end else if (last_shift_s && (k_r != K_W'(N_ELEM - 1))) begin
        k_r <= k_r + K_W'(1);
      end
      if (state_r == LOAD) begin
        cnt_r <= '0;
      end else if (state_r == SHIFT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Shadow bank collects finished elements so the visible frame is never partial.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_bcd_r   <= '0;
      shadow_blank_r <= '0;
    end else if (last_shift_s) begin
      shadow_bcd_r[digit_lsb(int'(k_r), 0, DIGITS) +: DW] <= core_bcd_s;
      shadow_blank_r[int'(k_r)*DIGITS +: DIGITS]          <= blank_of(core_bcd_s);
    end
  end

  // Commit registers feeding the display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_out       <= '0;
      blank_out     <= BLANK_RST;
      frame_updated <= 1'b0;
    end else if (commit_s) begin
      bcd_out       <= shadow_bcd_r;
      blank_out     <= shadow_blank_r;
      frame_updated <= 1'b1;
    end else begin
      frame_updated <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_bcd_formatter.sv
// Scoreboard bench for matrix_bcd_formatter: directed matrices with hand-computed BCD frames.
module tb_matrix_bcd_formatter;

  typedef struct packed {
    logic [7:0]  v;
    logic [11:0] bcd;
    logic [2:0]  blk;
  } ent_t;
  typedef ent_t mat_t [9];

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [71:0]   in_data;
  logic          vblank;
  logic [107:0]  bcd_out;
  logic [26:0]   blank_out;
  logic          busy;
  logic          frame_updated;

  int            checks;
  int            errors;
  int            cyc;
  int            acc_cyc;
  logic [134:0]  sb [$];

  matrix_bcd_formatter #(.DATA_W(8), .DIGITS(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .vblank        (vblank),
    .bcd_out       (bcd_out),
    .blank_out     (blank_out),
    .busy          (busy),
    .frame_updated (frame_updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every committed frame must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && frame_updated) begin
      if (sb.size() == 0) begin
        chk("unexpected_commit", 128'd1, 128'd0);
      end else begin
        logic [134:0] e;
        e = sb.pop_front();
        chk("frame_bcd", {20'd0, bcd_out}, {20'd0, e[134:27]});
        chk("frame_blank", {101'd0, blank_out}, {101'd0, e[26:0]});
      end
    end
  end

  task automatic send(input mat_t m, input bit hold, input bit jitter, output logic [107:0] eb);
    logic [71:0] d;
    logic [26:0] el;
    logic [95:0] r;
    int n;
    for (int i = 0; i < 9; i++) begin
      d[i*8 +: 8]   = m[i].v;
      eb[i*12 +: 12] = m[i].bcd;
      el[i*3 +: 3]  = m[i].blk;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 2000) begin
      if (jitter) begin
        r = {$urandom(), $urandom(), $urandom()};
        in_data = r[71:0];
      end
      @(negedge clk);
      n++;
    end
    in_data = d;
    if (!in_ready) begin
      chk("accept_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
    end else begin
      sb.push_back({eb, el});
      @(negedge clk);
      acc_cyc = cyc;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_commit(input int max_cyc);
    int n;
    n = 0;
    while (!frame_updated && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!frame_updated) chk("commit_timeout", 128'd0, 128'd1);
  endtask

  localparam logic [26:0] BLANK_RST = {9{3'b110}};

  initial begin
    mat_t m2, m3, m4, m5, m6, ma, mb;
    logic [107:0] eb, eb_prev;
    int pulses, acc_a, acc_b;

    m2 = '{'{8'd91, 12'h091, 3'b100}, '{8'd1, 12'h001, 3'b110}, '{8'd1, 12'h001, 3'b110},
           '{8'd1, 12'h001, 3'b110}, '{8'd1, 12'h001, 3'b110}, '{8'd1, 12'h001, 3'b110},
           '{8'd1, 12'h001, 3'b110}, '{8'd1, 12'h001, 3'b110}, '{8'd1, 12'h001, 3'b110}};
    m3 = '{'{8'd0, 12'h000, 3'b110}, '{8'd9, 12'h009, 3'b110}, '{8'd10, 12'h010, 3'b100},
           '{8'd99, 12'h099, 3'b100}, '{8'd100, 12'h100, 3'b000}, '{8'd255, 12'h255, 3'b000},
           '{8'd7, 12'h007, 3'b110}, '{8'd50, 12'h050, 3'b100}, '{8'd200, 12'h200, 3'b000}};
    m4 = '{'{8'd128, 12'h128, 3'b000}, '{8'd64, 12'h064, 3'b100}, '{8'd32, 12'h032, 3'b100},
           '{8'd16, 12'h016, 3'b100}, '{8'd8, 12'h008, 3'b110}, '{8'd4, 12'h004, 3'b110},
           '{8'd2, 12'h002, 3'b110}, '{8'd1, 12'h001, 3'b110}, '{8'd0, 12'h000, 3'b110}};
    m5 = '{'{8'd11, 12'h011, 3'b100}, '{8'd22, 12'h022, 3'b100}, '{8'd33, 12'h033, 3'b100},
           '{8'd44, 12'h044, 3'b100}, '{8'd55, 12'h055, 3'b100}, '{8'd66, 12'h066, 3'b100},
           '{8'd77, 12'h077, 3'b100}, '{8'd88, 12'h088, 3'b100}, '{8'd99, 12'h099, 3'b100}};
    m6 = '{'{8'd250, 12'h250, 3'b000}, '{8'd5, 12'h005, 3'b110}, '{8'd45, 12'h045, 3'b100},
           '{8'd145, 12'h145, 3'b000}, '{8'd201, 12'h201, 3'b000}, '{8'd3, 12'h003, 3'b110},
           '{8'd30, 12'h030, 3'b100}, '{8'd123, 12'h123, 3'b000}, '{8'd255, 12'h255, 3'b000}};
    ma = '{'{8'd17, 12'h017, 3'b100}, '{8'd170, 12'h170, 3'b000}, '{8'd6, 12'h006, 3'b110},
           '{8'd60, 12'h060, 3'b100}, '{8'd101, 12'h101, 3'b000}, '{8'd19, 12'h019, 3'b100},
           '{8'd90, 12'h090, 3'b100}, '{8'd109, 12'h109, 3'b000}, '{8'd2, 12'h002, 3'b110}};
    mb = '{'{8'd222, 12'h222, 3'b000}, '{8'd0, 12'h000, 3'b110}, '{8'd249, 12'h249, 3'b000},
           '{8'd49, 12'h049, 3'b100}, '{8'd5, 12'h005, 3'b110}, '{8'd150, 12'h150, 3'b000},
           '{8'd15, 12'h015, 3'b100}, '{8'd1, 12'h001, 3'b110}, '{8'd240, 12'h240, 3'b000}};

    checks = 0; errors = 0; cyc = 0; acc_cyc = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; vblank = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_bcd", {20'd0, bcd_out}, 128'd0);
    chk("rst_blank", {101'd0, blank_out}, {101'd0, BLANK_RST});
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_busy", {127'd0, busy}, 128'd0);

    // Basic conversion with vblank held high: minimum latency.
    vblank = 1'b1;
    send(m2, 1'b0, 1'b0, eb);
    chk("busy_while_converting", {127'd0, busy}, 128'd1);
    wait_commit(200);
    chk("latency_edges", 128'(cyc - acc_cyc), 128'd82);
    chk("in_ready_after_commit", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    chk("frame_updated_one_cycle", {127'd0, frame_updated}, 128'd0);
    chk("idle_busy", {127'd0, busy}, 128'd0);

    // Digit-count boundaries.
    send(m3, 1'b0, 1'b0, eb_prev);
    wait_commit(200);
    @(negedge clk);

    // Commit held off until vblank.
    vblank = 1'b0;
    send(m4, 1'b0, 1'b0, eb);
    pulses = 0;
    repeat (500) begin
      @(negedge clk);
      if (frame_updated) pulses++;
    end
    chk("no_commit_without_vblank", 128'(pulses), 128'd0);
    chk("bcd_held", {20'd0, bcd_out}, {20'd0, eb_prev});
    chk("in_ready_low_waiting", {127'd0, in_ready}, 128'd0);
    vblank = 1'b1;
    @(negedge clk);
    chk("commit_next_edge", {127'd0, frame_updated}, 128'd1);
    @(negedge clk);

    // Reset in the middle of element 4.
    send(m5, 1'b0, 1'b0, eb);
    repeat (38) @(negedge clk);
    chk("busy_before_reset", {127'd0, busy}, 128'd1);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_bcd", {20'd0, bcd_out}, 128'd0);
    chk("mid_rst_blank", {101'd0, blank_out}, {101'd0, BLANK_RST});
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(m6, 1'b0, 1'b0, eb);
    wait_commit(200);
    @(negedge clk);

    // in_valid held with changing data while busy.
    send(ma, 1'b1, 1'b0, eb);
    acc_a = acc_cyc;
    send(mb, 1'b0, 1'b1, eb);
    acc_b = acc_cyc;
    chk("back_to_back_accept", 128'(acc_b - acc_a), 128'd83);
    wait_commit(200);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
